// File: rtl/systolic_setup_out.sv
// systolic_setup_out: de-skews the staggered column outputs of a MAC_WIDTH x MAC_WIDTH
// systolic array into a full matrix and holds it for a valid/ready consumer.
// Column c runs through MAC_WIDTH-1-c delay stages so that all elements of one row
// appear together. Completed rows are written into a row buffer. When the last row
// is written, the block stops accepting input until the consumer takes the matrix.
// Optional macro SETUP_OUT_SKEW_CHECK_EN: flags partially aligned rows (sticky
// skew_err) and drops them. Without the macro, column 0 alone qualifies a row.

// One column's delay line, DEPTH >= 1 stages of data plus valid, shifting on shift_en.
module systolic_setup_out_dly #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic [DATA_SIZE-1:0] d_in,
  input  logic                 v_in,
  output logic [DATA_SIZE-1:0] d_out,
  output logic                 v_out
);

  logic [DEPTH-1:0][DATA_SIZE-1:0] dat_q, dat_d;
  logic [DEPTH-1:0]                vld_q, vld_d;

  // Shift the whole line by one stage when upstream data is being accepted.
  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (shift_en) begin
      dat_d[0] = d_in;
      vld_d[0] = v_in;
      for (int i = 1; i < DEPTH; i++) begin
        dat_d[i] = dat_q[i-1];
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  // Stage registers; valids clear on reset so partial rows are discarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dat_q <= '0;
      vld_q <= '0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign d_out = dat_q[DEPTH-1];
  assign v_out = vld_q[DEPTH-1];

endmodule

module systolic_setup_out #(
  parameter int DATA_SIZE = 8,
  parameter int MAC_WIDTH = 4
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [DATA_SIZE*MAC_WIDTH-1:0]               data_in,
  input  logic [MAC_WIDTH-1:0]                         valid_in,
  output logic                                         in_ready,
  output logic [DATA_SIZE*MAC_WIDTH*MAC_WIDTH-1:0]     matrix_out,
  output logic                                         matrix_out_valid,
  input  logic                                         matrix_out_ready,
  output logic                                         skew_err
);

  localparam int CW = (MAC_WIDTH > 1) ? $clog2(MAC_WIDTH) : 1;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                                        state_q, state_d;
  logic                                          in_ready_q, in_ready_d;
  logic                                          mov_q, mov_d;
  logic [CW-1:0]                                 row_cnt_q, row_cnt_d;
  logic [MAC_WIDTH-1:0][MAC_WIDTH-1:0][DATA_SIZE-1:0] buf_q, buf_d;

  logic [MAC_WIDTH-1:0][DATA_SIZE-1:0] col_in;
  logic [MAC_WIDTH-1:0][DATA_SIZE-1:0] row_data;
  logic [MAC_WIDTH-1:0]                row_vld;
  logic                                row_hit;
  logic                                row_wr;
  logic                                last_row;

  assign col_in = data_in;

  // Per-column de-skew: the rightmost column arrives last and needs no delay.
  for (genvar c = 0; c < MAC_WIDTH; c++) begin : g_col
    if (MAC_WIDTH - 1 - c == 0) begin : g_pass
      assign row_data[c] = col_in[c];
      assign row_vld[c]  = valid_in[c];
    end else begin : g_dly
      systolic_setup_out_dly #(
        .DATA_SIZE(DATA_SIZE),
        .DEPTH    (MAC_WIDTH - 1 - c)
      ) u_dly (
        .clock   (clock),
        .reset   (reset),
        .shift_en(in_ready_q),
        .d_in    (col_in[c]),
        .v_in    (valid_in[c]),
        .d_out   (row_data[c]),
        .v_out   (row_vld[c])
      );
    end
  end

`ifdef SETUP_OUT_SKEW_CHECK_EN
  logic row_partial;
  logic skew_q, skew_d;

  assign row_hit     = &row_vld;
  assign row_partial = (|row_vld) & ~(&row_vld);

  // Any misaligned row seen while accepting input latches the error until reset.
  always_comb begin
    skew_d = skew_q | (in_ready_q & row_partial);
  end

  // Sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) skew_q <= 1'b0;
    else       skew_q <= skew_d;
  end

  assign skew_err = skew_q;
`else
  logic unused_vld;

  // Without the check, column 0 alone qualifies the aligned row.
  assign row_hit    = row_vld[0];
  assign unused_vld = ^row_vld;
  assign skew_err   = 1'b0;
`endif

  assign row_wr   = in_ready_q & row_hit;
  assign last_row = (row_cnt_q == CW'(MAC_WIDTH - 1));

  // Next-state: collect rows into the buffer, then hold until the consumer accepts.
  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    mov_d      = mov_q;
    row_cnt_d  = row_cnt_q;
    buf_d      = buf_q;
    case (state_q)
      COLLECT: begin
        in_ready_d = 1'b1;
        mov_d      = 1'b0;
        if (row_wr) begin
          buf_d[row_cnt_q] = row_data;
          if (last_row) begin
            row_cnt_d  = '0;
            state_d    = HOLD;
            in_ready_d = 1'b0;
            mov_d      = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        in_ready_d = 1'b0;
        mov_d      = 1'b1;
        if (mov_q && matrix_out_ready) begin
          state_d    = COLLECT;
          in_ready_d = 1'b1;
          mov_d      = 1'b0;
        end
      end
      default: begin
        state_d    = COLLECT;
        in_ready_d = 1'b0;
        mov_d      = 1'b0;
      end
    endcase
  end

  // State, registered handshake outputs, row counter and matrix buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= COLLECT;
      in_ready_q <= 1'b0;
      mov_q      <= 1'b0;
      row_cnt_q  <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      mov_q      <= mov_d;
      row_cnt_q  <= row_cnt_d;
      buf_q      <= buf_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign matrix_out_valid = mov_q;
  assign matrix_out       = buf_q;

endmodule

// File: doc/systolic_setup_out.md
SYSTOLIC_SETUP_OUT -- requirements
Module: systolic_setup_out

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, meaning bit width of one result element.
REQ-002 The block SHALL have parameter MAC_WIDTH, default 4, meaning array dimension (rows = columns = MAC_WIDTH).
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-005 The block SHALL have port data_in, input, DATA_SIZE*MAC_WIDTH bits, skewed column outputs of the array; column c is at bits [c*DATA_SIZE +: DATA_SIZE].
REQ-006 The block SHALL have port valid_in, input, MAC_WIDTH bits, per-column element valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit; high when the block accepts and shifts data_in.
REQ-008 The block SHALL have port matrix_out, output, DATA_SIZE*MAC_WIDTH*MAC_WIDTH bits; element (r,c) is at bits [(r*MAC_WIDTH+c)*DATA_SIZE +: DATA_SIZE].
REQ-009 The block SHALL have port matrix_out_valid, output, 1 bit, full de-skewed matrix present.
REQ-010 The block SHALL have port matrix_out_ready, input, 1 bit, consumer accepts matrix.
REQ-011 The block SHALL have port skew_err, output, 1 bit, sticky misalignment flag.

Function
REQ-012 Upstream SHALL present row r, column c at cycle (r+c) relative to row 0, column 0; valid_in SHALL be honoured only in cycles where in_ready=1.
REQ-013 Column c SHALL pass through a delay line of MAC_WIDTH-1-c register stages (data and valid) that shifts only when in_ready=1; column MAC_WIDTH-1 has zero stages.
REQ-014 The aligned row SHALL be the delay-line outputs of all columns in the same cycle; row_hit SHALL be the AND of all aligned valids (see REQ-026 for the macro-off case).
REQ-015 On a row_hit edge with in_ready=1, the aligned row SHALL be written into buffer row row_cnt, and row_cnt SHALL increment.
REQ-016 States SHALL be COLLECT (in_ready=1, matrix_out_valid=0) and HOLD (in_ready=0, matrix_out_valid=1).
REQ-017 COLLECT->HOLD SHALL occur on the same edge that writes row MAC_WIDTH-1; row_cnt SHALL wrap to 0 on that edge.
REQ-018 HOLD->COLLECT SHALL occur on the edge where matrix_out_valid=1 and matrix_out_ready=1; in_ready SHALL be 1 in the following cycle.
REQ-019 In HOLD, delay lines, row_cnt and buffer SHALL be frozen; matrix_out SHALL be stable until accepted.
REQ-020 Latency: column-0 element of row 0 sampled at edge T SHALL reach buffer at edge T+MAC_WIDTH-1; matrix_out_valid SHALL rise at edge T+2*MAC_WIDTH-2 for back-to-back rows.
REQ-021 matrix_out_ready asserted while matrix_out_valid=0 SHALL have no effect.
REQ-022 Data SHALL be stored unmodified; no arithmetic, truncation or sign extension.

Reset
REQ-023 While reset=1: state=COLLECT, row_cnt=0, all delay-line valids=0, buffer=0, matrix_out=0, matrix_out_valid=0, in_ready=0, skew_err=0.
REQ-024 in_ready SHALL be 1 from the first edge after reset deasserts; assertion of reset mid-collection or in HOLD SHALL discard all partial rows and the held matrix.

Configuration
REQ-025 With macro SETUP_OUT_SKEW_CHECK_EN defined, in a cycle with in_ready=1 where some but not all aligned valids are 1, skew_err SHALL set and hold until reset; that partial row SHALL be dropped, and row_cnt SHALL NOT increment.
REQ-026 With SETUP_OUT_SKEW_CHECK_EN undefined, row_hit SHALL equal the aligned valid of column 0 alone, and skew_err SHALL be tied to 0.

Verification
REQ-027 Bench SHALL cover, with MAC_WIDTH=4, DATA_SIZE=8, element(r,c)=16r+c fed at cycles r+c, ready=1 -> matrix_out_valid rises at edge 6 and matrix_out exactly equals {16r+c}.
REQ-028 Bench SHALL cover: matrix_out_ready held 0 for 10 cycles after valid -> in_ready=0 and matrix_out stable for 10 cycles; ready=1 -> valid drops next cycle and in_ready=1.
REQ-029 Bench SHALL cover: two matrices streamed back to back, second stalled by HOLD -> both received intact, in order, with no element loss.
REQ-030 Bench SHALL cover: reset pulsed after row 2 is written -> all outputs 0; a fresh matrix then yields correct output with no stale rows.
REQ-031 Bench SHALL cover, with the macro defined: column 2 of row 1 presented one cycle late -> skew_err=1 sticky and row 1 dropped; with the macro undefined -> skew_err=0.
